popcount_accum: RTL
===================

POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of bits per input word, minimum 1.
REQ-002 The block SHALL have parameter ACC_W, default 8: width of the frame accumulator, minimum 2.
REQ-003 The block SHALL define CNT_W = clog2(WIDTH+1) as a derived local constant: width of the per-word count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is presented this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the word to count.
REQ-008 The block SHALL have port in_last, input, 1 bit: the word is the final word of a frame; qualified by in_valid.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous abort of the frame in progress.
REQ-010 The block SHALL have port word_valid, output, 1 bit: one-cycle pulse marking a new word_count.
REQ-011 The block SHALL have port word_count, output, CNT_W bits: number of ones in the last accepted word.
REQ-012 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-013 The block SHALL have port frame_count, output, ACC_W bits: total number of ones in the last completed frame.
REQ-014 The block SHALL have port frame_sat, output, 1 bit: the last completed frame saturated.
REQ-015 The block SHALL have port busy, output, 1 bit: a frame is open (state ACCUM).

Function
REQ-016 A word SHALL be accepted on every rising clk edge with in_valid=1 and clear=0; there is no backpressure.
REQ-017 word_count SHALL equal popcount(in_data) of the accepted word, registered; word_valid SHALL be 1 in the cycle after acceptance (latency 1).
REQ-018 The FSM SHALL have two states, IDLE and ACCUM; busy SHALL be 1 only in ACCUM.
REQ-019 In IDLE, an accepted word with in_last=0 SHALL load acc with popcount, clear the sticky sat bit, and move to ACCUM.
REQ-020 In IDLE, an accepted word with in_last=1 SHALL be a one-word frame: frame_count=popcount, frame_sat=0, frame_valid pulses next cycle, state stays IDLE.
REQ-021 In ACCUM, an accepted word with in_last=0 SHALL add popcount to acc and stay in ACCUM.
REQ-022 In ACCUM, an accepted word with in_last=1 SHALL present acc+popcount on frame_count with frame_valid next cycle, zero acc, and return to IDLE.
REQ-023 Addition SHALL saturate at 2^ACC_W-1; any clamp during a frame SHALL set a sticky bit reported as frame_sat with that frame.
REQ-024 in_valid=0 cycles SHALL leave acc, state and all outputs unchanged, except that word_valid and frame_valid drop to 0.
REQ-025 clear=1 SHALL take priority over in_valid: acc=0, sat=0, state=IDLE, the word presented that cycle is discarded, and no valid pulse results.
REQ-026 frame_count, frame_sat and word_count SHALL hold their values until overwritten by the next frame or word.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, acc=0, sat=0, word_valid=0, word_count=0, frame_valid=0, frame_count=0, frame_sat=0, busy=0.
REQ-028 An open frame SHALL be discarded on reset, and operation SHALL resume on the first rising clk edge after rst_n returns to 1.

Verification (WIDTH=4, ACC_W=8 unless stated)
REQ-029 Bench SHALL cover a single-word frame: in_data=1111 with in_last=1 -> next cycle word_count=4, frame_count=4, frame_valid=1, busy=0.
REQ-030 Bench SHALL cover a three-word frame: 0001, 0110, 1011 (last) with a one-cycle bubble between words -> word_count=1, 2, 3 in turn; frame_count=6 one cycle after the last word; busy=1 between the first and last words.
REQ-031 Bench SHALL cover saturation: with ACC_W=4, five words of 1111 (last on the fifth) -> frame_count=15, frame_sat=1; the next frame, 0001 (last), -> frame_count=1, frame_sat=0.
REQ-032 Bench SHALL cover clear mid-frame: 1111, 1111, then clear=1 together with in_valid=1 -> no pulses and busy=0; then 0011 (last) -> frame_count=2.
REQ-033 Bench SHALL cover asynchronous reset: rst_n low between edges during an open frame -> all outputs 0 before the next edge; a following 0101 (last) -> frame_count=2.
REQ-034 Bench SHALL cover the WIDTH=1 boundary: a frame of 1, 0, 1 (last) -> frame_count=2, with word_count one bit wide.

Source files
------------

// File: rtl/popcount_accum_if.sv
// rtl/popcount_accum_if.sv - word stream in, per-word and per-frame popcount results out
interface popcount_accum_if #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             clear;
    logic             word_valid;
    logic [CNT_W-1:0] word_count;
    logic             frame_valid;
    logic [ACC_W-1:0] frame_count;
    logic             frame_sat;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_last, clear,
        output word_valid, word_count, frame_valid, frame_count, frame_sat, busy
    );

    modport master (
        output in_valid, in_data, in_last, clear,
        input  word_valid, word_count, frame_valid, frame_count, frame_sat, busy
    );
endinterface

// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - counts ones per word and sums them, saturating, over each frame
module popcount_accum #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    popcount_accum_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    // One spare bit so the clamp test sees the carry even if the count is wider than acc.
    localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic               word_valid_q, word_valid_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic               frame_valid_q, frame_valid_d;
    logic [ACC_W-1:0]   frame_count_q, frame_count_d;
    logic               frame_sat_q, frame_sat_d;

    logic [CNT_W-1:0]   pc;
    logic [ACC_W-1:0]   base;
    logic [SUM_W-1:0]   sum;
    logic               clamp;
    logic [ACC_W-1:0]   acc_new;
    logic               sat_new;

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + CNT_W'(bus.in_data[i]);
        end

        // A word arriving in IDLE starts a fresh frame, so the old acc/sat are ignored.
        base    = (state_q == ACCUM) ? acc_q : '0;
        sum     = SUM_W'(base) + SUM_W'(pc);
        clamp   = (sum > ACC_MAX);
        acc_new = clamp ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        sat_new = ((state_q == ACCUM) && sat_q) || clamp;

        state_d       = state_q;
        acc_d         = acc_q;
        sat_d         = sat_q;
        word_valid_d  = 1'b0;
        word_count_d  = word_count_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        frame_sat_d   = frame_sat_q;

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            sat_d   = 1'b0;
        end else if (bus.in_valid) begin
            word_valid_d = 1'b1;
            word_count_d = pc;
            if (bus.in_last) begin
                frame_valid_d = 1'b1;
                frame_count_d = acc_new;
                frame_sat_d   = sat_new;
                acc_d         = '0;
                sat_d         = 1'b0;
                state_d       = IDLE;
            end else begin
                acc_d   = acc_new;
                sat_d   = sat_new;
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            word_valid_q  <= 1'b0;
            word_count_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            frame_sat_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            word_valid_q  <= word_valid_d;
            word_count_q  <= word_count_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            frame_sat_q   <= frame_sat_d;
        end
    end

    assign bus.word_valid  = word_valid_q;
    assign bus.word_count  = word_count_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.frame_sat   = frame_sat_q;
    assign bus.busy        = (state_q == ACCUM);
endmodule
